// File: rtl/fetch_pkg.sv
// Shared fetch-path types: word width, NOP encoding, queue entry layout and occupancy states.
// Used by the PC, prefetch queue and decode stages; no logic of its own.
package fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0;

    typedef struct packed {
        logic [WORD_W-1:0] pc1;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FQ_EMPTY,
        FQ_PARTIAL,
        FQ_FULL
    } fq_state_e;

    function automatic fq_state_e fq_state(input int cnt, input int depth);
        if (cnt == 0)
            return FQ_EMPTY;
        else if (cnt >= depth)
            return FQ_FULL;
        else
            return FQ_PARTIAL;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bundle: push side from fetch, head/pop side to decode, plus status.
// master = fetch/decode/flush drivers, slave = the queue itself.
interface fetch_queue_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             push;
    logic [WIDTH-1:0] push_pc1;
    logic [WIDTH-1:0] push_instr;
    logic             full;
    logic             pop;
    logic             out_valid;
    logic [WIDTH-1:0] out_pc1;
    logic [WIDTH-1:0] out_instr;
    logic             flush;
    logic [CNT_W-1:0] count;
    logic             err_overflow;
    logic             err_underflow;

    modport master (
        output push, push_pc1, push_instr, pop, flush,
        input  full, out_valid, out_pc1, out_instr, count, err_overflow, err_underflow
    );

    modport slave (
        input  push, push_pc1, push_instr, pop, flush,
        output full, out_valid, out_pc1, out_instr, count, err_overflow, err_underflow
    );

endinterface

// File: rtl/fq_storage.sv
// Queue register file: one synchronous write port, one asynchronous read port, no reset.
// Write visible on the read port one cycle later; no backpressure (caller gates wr_en).
module fq_storage #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[wr_addr] = wr_dat;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO (first-word-fall-through): push-to-head latency 1 cycle, no bypass.
// Backpressure via full decoded from registered count; pushes while full are dropped and flagged.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WORD_W
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_unf_q, err_unf_d;

    logic               push_acc;
    logic               pop_acc;
    logic               full;
    logic               out_valid;
    fq_state_e          state;
    logic [2*WIDTH-1:0] head_dat;

    // Status comes from registered count only, keeping push/pop/flush off the full path.
    assign state     = fq_state(int'(count_q), DEPTH);
    assign full      = (state == FQ_FULL);
    assign out_valid = (state != FQ_EMPTY);

    always_comb begin
        push_acc  = fq.push && !full && !fq.flush;
        pop_acc   = fq.pop && out_valid && !fq.flush;

        wr_ptr_d  = wr_ptr_q + PTR_W'(push_acc);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_acc);
        count_d   = count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);

        // Wrong-path traffic during a flush is discarded silently.
        err_ovf_d = err_ovf_q | (fq.push & full & ~fq.flush);
        err_unf_d = err_unf_q | (fq.pop & ~out_valid & ~fq.flush);

        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    fq_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (2*WIDTH)
    ) u_storage (
        .clk     (clk),
        .wr_en   (push_acc),
        .wr_addr (wr_ptr_q),
        .wr_dat  ({fq.push_pc1, fq.push_instr}),
        .rd_addr (rd_ptr_q),
        .rd_dat  (head_dat)
    );

    assign fq.full          = full;
    assign fq.out_valid     = out_valid;
    assign fq.out_pc1       = out_valid ? head_dat[2*WIDTH-1:WIDTH] : '0;
    assign fq.out_instr     = out_valid ? head_dat[WIDTH-1:0] : WIDTH'(NOP_INSTR);
    assign fq.count         = count_q;
    assign fq.err_overflow  = err_ovf_q;
    assign fq.err_underflow = err_unf_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic vs a queue model.
// Model keeps entries in a SystemVerilog queue and sticky flags as plain bits.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) fq_bus ();

    fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .fq    (fq_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fq_entry_t mq[$];
    bit        m_ovf;
    bit        m_unf;
    int        n_cmp;
    int        n_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        fq_entry_t head;
        bit        nonempty;
        nonempty = (mq.size() != 0);
        head     = nonempty ? mq[0] : '0;
        check_eq("count",     64'(fq_bus.count),     64'(mq.size()));
        check_eq("out_valid", 64'(fq_bus.out_valid), 64'(nonempty));
        check_eq("full",      64'(fq_bus.full),      64'(mq.size() == DEPTH));
        check_eq("out_instr", 64'(fq_bus.out_instr), nonempty ? 64'(head.instr) : 64'(NOP_INSTR));
        check_eq("out_pc1",   64'(fq_bus.out_pc1),   64'(head.pc1));
        check_eq("err_ovf",   64'(fq_bus.err_overflow),  64'(m_ovf));
        check_eq("err_unf",   64'(fq_bus.err_underflow), 64'(m_unf));
    endtask

    // One clock: drive inputs, advance model on the edge, check #1 later.
    task automatic step(input logic rs, input logic p, input logic [31:0] pc,
                        input logic [31:0] ins, input logic po, input logic fl);
        bit was_full;
        bit was_empty;
        fq_entry_t e;
        reset             = rs;
        fq_bus.push       = p;
        fq_bus.push_pc1   = pc;
        fq_bus.push_instr = ins;
        fq_bus.pop        = po;
        fq_bus.flush      = fl;
        @(posedge clk);
        if (!rs) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            if (p && was_full)  m_ovf = 1;
            if (po && was_empty) m_unf = 1;
            if (po && !was_empty) void'(mq.pop_front());
            if (p && !was_full) begin
                e.pc1   = pc;
                e.instr = ins;
                mq.push_back(e);
            end
        end
        #1;
        compare_all();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_ovf = 0;
        m_unf = 0;
        reset = 1'b0;
        fq_bus.push = 1'b0; fq_bus.push_pc1 = '0; fq_bus.push_instr = '0;
        fq_bus.pop = 1'b0;  fq_bus.flush = 1'b0;

        // Reset then idle
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);

        // Fill to full, then drain in order
        for (int i = 0; i < 4; i++) step(1, 1, 32'(i + 1), 32'hA0 + 32'(i), 0, 0);
        check_eq("full_after_fill", 64'(fq_bus.full), 64'd1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 0);
        check_eq("empty_after_drain", 64'(fq_bus.out_valid), 64'd0);

        // Overflow with simultaneous pop
        for (int i = 0; i < 4; i++) step(1, 1, 32'(i + 11), 32'hA0 + 32'(i), 0, 0);
        step(1, 1, 32'h99, 32'hBB, 1, 0);
        check_eq("ovf_count", 64'(fq_bus.count), 64'd3);
        check_eq("ovf_head", 64'(fq_bus.out_instr), 64'hA1);

        // Streaming at count 1 across pointer wrap
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 32'(100 + i), 32'hC00 + 32'(i), 1, 0);

        // Flush with a wrong-path push, then a fresh push
        step(1, 1, 32'h200, 32'hD1, 0, 0);
        step(1, 1, 32'h201, 32'hD2, 0, 0);
        step(1, 1, 32'h300, 32'hCC, 0, 1);
        step(1, 1, 32'h301, 32'hDD, 0, 0);
        check_eq("post_flush_head", 64'(fq_bus.out_instr), 64'hDD);

        // Underflow, then reset mid-operation
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 1, 32'h400, 32'hE0, 0, 0);
        step(1, 1, 32'h401, 32'hE1, 0, 0);
        step(0, 1, 32'h402, 32'hE2, 1, 0);
        step(1, 0, 0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                 $urandom, $urandom,
                 ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction prefetch queue between the program-counter/instruction-memory fetch stage and the decode stage of the segmented processor. It buffers up to DEPTH fetched {PC+1, instruction} pairs and presents the oldest one to decode in first-word-fall-through order. It back-pressures the PC with full, and discards all wrong-path entries on a taken branch (flush).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2.
WIDTH, 32, width of instruction word and of PC+1 (word-addressed PC).

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
push  in  1  fetch presents a valid instruction this cycle.
push_pc1  in  WIDTH  PC+1 of the fetched instruction.
push_instr  in  WIDTH  fetched instruction word.
full  out  1  queue holds DEPTH entries; PC must hold its value.
pop  in  1  decode consumes the head entry this cycle.
out_valid  out  1  head entry valid (queue not empty).
out_pc1  out  WIDTH  PC+1 of head entry.
out_instr  out  WIDTH  head instruction; NOP when not valid.
flush  in  1  taken branch: discard every queued entry.
count  out  clog2(DEPTH)+1  number of valid entries.
err_overflow  out  1  sticky: push seen while full.
err_underflow  out  1  sticky: pop seen while empty.

Behaviour:
- Reset (reset==0 at rising clk): rd/wr pointers=0, count=0, full=0, out_valid=0, out_pc1=0, out_instr=NOP (32'h0), err_overflow=0, err_underflow=0. Storage contents need not be cleared. Reset has priority over every other input.
- Storage: DEPTH x (2*WIDTH) registers, circular, write pointer and read pointer each clog2(DEPTH) bits, wrap from DEPTH-1 to 0 naturally.
- full = (count==DEPTH); out_valid = (count!=0); both decode registered count only (no combinational path from push/pop/flush).
- Head outputs are combinational reads of storage[rd_ptr]; out_instr and out_pc1 forced to 0 when out_valid==0.
- Push accepted iff push && !full && !flush: write at wr_ptr, wr_ptr+1. Write-to-read latency 1 cycle: a push into an empty queue makes out_valid=1 on the next cycle; no same-cycle bypass.
- Pop accepted iff pop && out_valid && !flush: rd_ptr+1.
- Push while full is dropped (entry not stored, pointers unchanged) and sets err_overflow. A simultaneous pop does not make room in that cycle.
- Pop while empty is ignored and sets err_underflow.
- Accepted push and accepted pop in the same cycle: count unchanged, both pointers advance.
- flush==1 (with reset==1): count=0, rd_ptr=wr_ptr=0 next cycle; a same-cycle push is discarded as wrong-path (no error flag); a same-cycle pop is ignored (no error flag). Sticky flags are not cleared by flush.
- Error flags cleared only by reset.
- No internal FSM beyond the count/pointer state; the states are EMPTY (count 0), PARTIAL, and FULL (count DEPTH), derived from count.

Decomposition:
- Shared package fetch_pkg: WORD_W=32, NOP_INSTR=32'h0, typedef fq_entry_t {pc1, instr}. The package is shared with the PC and decode stages.
- One natural sub-module: fq_storage (DEPTH-entry register file, one write port, one asynchronous read port). Pointer/count control stays in fetch_queue.

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> count=0, out_valid=0, out_instr=0, full=0, both error flags 0.
- Fill/drain order: push pc1=1..4 with instr 0xA0..0xA3 on consecutive cycles, no pop -> full=1 after the 4th push. Then pop 4x -> out_instr 0xA0,0xA1,0xA2,0xA3 in order; out_valid=0 afterwards.
- Overflow: with the queue full, push instr 0xBB with pop=1 -> 0xBB not stored, err_overflow=1, count=3. The next head is the second entry.
- Streaming: push and pop every cycle for 10 cycles starting with count=1 -> count stays 1, and out_instr lags push_instr by exactly 1 entry across the pointer wrap.
- Flush: count=3, assert flush together with push=1, instr 0xCC -> next cycle count=0, out_valid=0, no error flags. A push of 0xDD on the following cycle appears at the head one cycle later.
- Underflow and reset mid-operation: pop on empty -> err_underflow=1. Then with count=2, assert reset=0 -> next cycle count=0 and both flags=0.
